serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: computes diff = a - b one bit per clock, LSB first.

---
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-adder slice computes a + ~b + 1
// LSB first, with a start/ready/done handshake and held result flags.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             a_i, nb_i, s, c_nxt, last;
  logic [WIDTH-1:0] acc_nxt;

  // Single full-adder slice on the current LSBs; the sum enters from the MSB side.
  always_comb begin
    a_i     = a_sh[0];
    nb_i    = ~b_sh[0];
    s       = a_i ^ nb_i ^ carry;
    c_nxt   = (a_i & nb_i) | (a_i & carry) | (nb_i & carry);
    acc_nxt = {s, acc[WIDTH-1:1]};
    last    = (cnt == LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result port and flags only move on the final RUN edge, so the previous answer stays visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      acc        <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b1;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= acc_nxt;
          carry <= c_nxt;
          if (last) begin
            diff       <= acc_nxt;
            borrow_out <= ~c_nxt;
            overflow   <= (a_i == nb_i) && (s != a_i);
            zero       <= (acc_nxt == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, hand-written
// handshake/reset sequences and randomized operations against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         ready, busy, done;
  logic [W-1:0] diff;
  logic         borrow_out, overflow, zero;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] prev_diff;
  logic         prev_borrow, prev_ovf, prev_zero;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] md, output logic mbo, output logic mov, output logic mz);
    int sd;
    md  = W'(int'(ma) - int'(mb));
    mbo = (int'(ma) < int'(mb));
    sd  = int'($signed(ma)) - int'($signed(mb));
    mov = (sd > 127) || (sd < -128);
    mz  = (md == 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " ready"}, 32'(ready), 32'd1);
    chk({tag, " busy"},  32'(busy),  32'd0);
    chk({tag, " done"},  32'(done),  32'd0);
  endtask

  task automatic check_result(input string tag);
    chk({tag, " diff"},   32'(diff),       32'(prev_diff));
    chk({tag, " borrow"}, 32'(borrow_out), 32'(prev_borrow));
    chk({tag, " ovf"},    32'(overflow),   32'(prev_ovf));
    chk({tag, " zero"},   32'(zero),       32'(prev_zero));
  endtask

  // One full operation, checking timing cycle by cycle; optional stray start mid-RUN.
  task automatic apply_stimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit stray);
    logic [W-1:0] md;
    logic         mbo, mov, mz;
    int           guard = 0;
    while (!ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!ready) chk("ready timeout", 32'(ready), 32'd1);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    chk("busy after accept", 32'(busy), 32'd1);
    model(ta, tb_v, md, mbo, mov, mz);
    for (int k = 1; k <= W; k++) begin
      if (stray && k == 3) begin a = 8'd1; b = 8'd1; start = 1'b1; end
      if (stray && k == 4) start = 1'b0;
      @(posedge clk); #1;
      if (k < W) begin
        chk("busy in run", 32'(busy), 32'd1);
        chk("no early done", 32'(done), 32'd0);
        chk("diff stable in run", 32'(diff), 32'(prev_diff));
      end
    end
    chk("done pulse", 32'(done), 32'd1);
    prev_diff = md; prev_borrow = mbo; prev_ovf = mov; prev_zero = mz;
    check_result("result");
    @(posedge clk); #1;
    check_idle_outputs("after done");
    check_result("held");
  endtask

  task automatic checkOutput_held_start();
    int first = -1, second = -1;
    a = 8'd50; b = 8'd20; start = 1'b1;
    for (int c = 0; c < 40 && second < 0; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) first = c; else second = c;
      end
    end
    start = 1'b0;
    chk("held start first done", 32'(first), 32'(W));
    chk("held start spacing", 32'(second - first), 32'(W + 2));
    chk("held start diff", 32'(diff), 32'd30);
    @(posedge clk); #1;
    prev_diff = 8'd30; prev_borrow = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
    prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
    #12;
    check_idle_outputs("reset");
    check_result("reset");
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_idle_outputs("idle");
      check_result("idle");
    end

    vecs[0] = '{8'd100,  8'd37,  8'd63,   1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h05,   8'h07,  8'hFE,   1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h5A,   8'h5A,  8'h00,   1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h80,   8'h01,  8'h7F,   1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h7F,   8'hFF,  8'h80,   1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h00,   8'hFF,  8'h01,   1'b1, 1'b0, 1'b0};
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].a, vecs[i].b, 1'b0);
      chk("vec diff",   32'(diff),       32'(vecs[i].diff));
      chk("vec borrow", 32'(borrow_out), 32'(vecs[i].borrow));
      chk("vec ovf",    32'(overflow),   32'(vecs[i].ovf));
      chk("vec zero",   32'(zero),       32'(vecs[i].zero));
    end

    apply_stimulus(8'd9, 8'd3, 1'b1);
    chk("stray start ignored", 32'(diff), 32'd6);

    checkOutput_held_start();

    // Async reset in the middle of an operation.
    a = 8'd10; b = 8'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
    check_idle_outputs("async reset");
    check_result("async reset");
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk); #1;
      chk("no done after reset", 32'(done), 32'd0);
    end
    apply_stimulus(8'd200, 8'd55, 1'b0);
    chk("post reset diff", 32'(diff), 32'd145);

    for (int i = 0; i < 1000; i++)
      apply_stimulus(W'($urandom), W'($urandom), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
